// File: rtl/kpg_pkg.sv
// Shared symbol codes and FSM state type for the kpg carry-resolver slice.
package kpg_pkg;

    localparam logic [7:0] SYM_K = 8'h6B;
    localparam logic [7:0] SYM_P = 8'h70;
    localparam logic [7:0] SYM_G = 8'h67;

    typedef enum logic {
        COLLECT,
        DONE
    } state_t;

endpackage

// File: rtl/kpg_resolve.sv
// Single-bit kpg resolution: turns one classification symbol plus incoming carry
// into a sum bit and an outgoing carry.
module kpg_resolve
    import kpg_pkg::*;
(
    input  logic [7:0] sym,
    input  logic       c_in,
    output logic       s,
    output logic       c_out,
    output logic       bad
);

    always_comb begin
        s     = c_in;
        c_out = 1'b0;
        bad   = 1'b0;
        case (sym)
            SYM_K: begin
                s     = c_in;
                c_out = 1'b0;
            end
            SYM_P: begin
                s     = ~c_in;
                c_out = c_in;
            end
            SYM_G: begin
                s     = c_in;
                c_out = 1'b1;
            end
            // Anything else (including uppercase) resolves as a kill and is flagged.
            default: begin
                s     = c_in;
                c_out = 1'b0;
                bad   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/kpg_decoder.sv
// Serial carry resolver: accepts WIDTH kpg symbols LSB first and presents the
// reconstructed sum word, carry-out and an invalid-symbol flag.
module kpg_decoder
    import kpg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cin,
    input  logic [7:0]       sym,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned   IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IW-1:0]    r_idx;
    logic             r_c;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_err;

    logic w_accept;
    logic w_first;
    logic w_last;
    logic w_c_in;
    logic w_s;
    logic w_c_out;
    logic w_bad;

    assign w_accept = sym_valid && sym_ready;
    assign w_first  = (r_idx == '0);
    assign w_last   = (r_idx == LAST_IDX);
    assign w_c_in   = w_first ? cin : r_c;

    kpg_resolve u_resolve (
        .sym   (sym),
        .c_in  (w_c_in),
        .s     (w_s),
        .c_out (w_c_out),
        .bad   (w_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        sym_ready    = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            COLLECT: begin
                sym_ready = 1'b1;
                if (sym_valid && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = COLLECT;
                end
            end
            default: w_state_next = COLLECT;
        endcase
    end

    // Sum bits are overwritten in place; stale bits are harmless while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_c    <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_sum[r_idx] <= w_s;
            r_c          <= w_c_out;
            r_err        <= w_first ? w_bad : (r_err | w_bad);
            if (w_last) begin
                r_cout <= w_c_out;
                r_idx  <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule
